// File: rtl/complex_alu_pkg.sv
// Shared types and widths for the sequential complex ALU.
// Imported by the top and the serial divider.
package complex_alu_pkg;
    localparam int DW    = 8;
    localparam int RW    = 16;
    localparam int QBITS = 17;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MUL  = 3'd2,
        OP_DIV  = 3'd3,
        OP_CONJ = 3'd4
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_t;
endpackage

// File: rtl/cplx_serial_div.sv
// Unsigned restoring divider, one quotient bit per clock.
// quotient/done expose the final iteration so the caller can register it.
module cplx_serial_div
    import complex_alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [QBITS-1:0] dividend,
    input  logic [QBITS-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [QBITS-1:0] quotient
);
    localparam logic [4:0] LAST = 5'(QBITS - 1);

    logic [QBITS-1:0] rem_q, rem_d;
    logic [QBITS-1:0] quo_q, quo_d;
    logic [QBITS-1:0] dsr_q;
    logic [QBITS-1:0] diff;
    logic [QBITS:0]   trial;
    logic [4:0]       cnt_q;
    logic             busy_q;

    // quo_q shifts the dividend out at the top and the quotient in at the bottom
    always_comb begin
        trial = {rem_q, quo_q[QBITS-1]};
        diff  = trial[QBITS-1:0] - dsr_q;
        if (trial >= {1'b0, dsr_q}) begin
            rem_d = diff;
            quo_d = {quo_q[QBITS-2:0], 1'b1};
        end else begin
            rem_d = trial[QBITS-1:0];
            quo_d = {quo_q[QBITS-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dsr_q  <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= dividend;
            dsr_q  <= divisor;
        end else if (busy_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == LAST) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy     = busy_q;
    assign done     = busy_q && (cnt_q == LAST);
    assign quotient = quo_d;
endmodule

// File: rtl/complex_alu_seq.sv
// Handshaked complex ADD/SUB/MUL/DIV/CONJ unit with registered results.
// DIV runs two serial dividers in parallel (real and |imag|).
module complex_alu_seq
    import complex_alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    op,
    input  logic [DW-1:0] r1,
    input  logic [DW-1:0] i1,
    input  logic [DW-1:0] r2,
    input  logic [DW-1:0] i2,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] re_out,
    output logic [RW-1:0] im_out,
    output logic          neg_re,
    output logic          neg_im,
    output logic          div_zero,
    output logic          op_err
);
    state_t state_q, state_d;
    logic [RW-1:0] re_q, re_d, im_q, im_d;
    logic neg_re_q, neg_re_d, neg_im_q, neg_im_d;
    logic dz_q, dz_d, oe_q, oe_d;
    logic nneg_q, nneg_d;

    logic [RW-1:0] p_r1r2, p_i1i2, p_r1i2, p_r2i1, p_r2r2, p_i2i2;
    logic [RW-1:0] sub_re, sub_im, mul_re, mul_im, conj_im;
    logic [QBITS-1:0] den, nre, nim_mag;
    logic nim_neg;

    logic re_busy, re_done, im_busy, im_done, div_start, accept;
    logic [QBITS-1:0] re_quo, im_quo;
    logic [RW-1:0] div_re, im_mag;

    assign p_r1r2 = RW'(r1) * RW'(r2);
    assign p_i1i2 = RW'(i1) * RW'(i2);
    assign p_r1i2 = RW'(r1) * RW'(i2);
    assign p_r2i1 = RW'(r2) * RW'(i1);
    assign p_r2r2 = RW'(r2) * RW'(r2);
    assign p_i2i2 = RW'(i2) * RW'(i2);

    assign sub_re  = RW'(r1) - RW'(r2);
    assign sub_im  = RW'(i1) - RW'(i2);
    assign mul_re  = p_r1r2 - p_i1i2;
    assign mul_im  = p_r1i2 + p_r2i1;
    assign conj_im = RW'(0) - RW'(i1);

    assign den     = QBITS'(p_r2r2) + QBITS'(p_i2i2);
    assign nre     = QBITS'(p_r1r2) + QBITS'(p_i1i2);
    assign nim_neg = p_r2i1 < p_r1i2;
    assign nim_mag = nim_neg ? QBITS'(p_r1i2 - p_r2i1)
                             : QBITS'(p_r2i1 - p_r1i2);

    assign in_ready  = (state_q == IDLE) && !(re_busy || im_busy);
    assign accept    = in_valid && in_ready;
    assign div_start = accept && (op == OP_DIV) && (den != '0);

    cplx_serial_div u_div_re (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (nre),
        .divisor  (den),
        .busy     (re_busy),
        .done     (re_done),
        .quotient (re_quo)
    );

    cplx_serial_div u_div_im (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (nim_mag),
        .divisor  (den),
        .busy     (im_busy),
        .done     (im_done),
        .quotient (im_quo)
    );

    assign div_re = re_quo[QBITS-1] ? '1 : re_quo[RW-1:0];
    assign im_mag = im_quo[QBITS-1] ? '1 : im_quo[RW-1:0];

    always_comb begin
        state_d  = state_q;
        re_d     = re_q;
        im_d     = im_q;
        neg_re_d = neg_re_q;
        neg_im_d = neg_im_q;
        dz_d     = dz_q;
        oe_d     = oe_q;
        nneg_d   = nneg_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = DONE;
                    neg_re_d = 1'b0;
                    neg_im_d = 1'b0;
                    dz_d     = 1'b0;
                    oe_d     = 1'b0;
                    case (op)
                        OP_ADD: begin
                            re_d = RW'(r1) + RW'(r2);
                            im_d = RW'(i1) + RW'(i2);
                        end
                        OP_SUB: begin
                            re_d     = sub_re;
                            im_d     = sub_im;
                            neg_re_d = sub_re[RW-1];
                            neg_im_d = sub_im[RW-1];
                        end
                        OP_MUL: begin
                            re_d     = mul_re;
                            im_d     = mul_im;
                            neg_re_d = mul_re[RW-1];
                            neg_im_d = mul_im[RW-1];
                        end
                        OP_DIV: begin
                            if (den == '0) begin
                                re_d = '1;
                                im_d = '1;
                                dz_d = 1'b1;
                            end else begin
                                state_d = DIV;
                                nneg_d  = nim_neg;
                            end
                        end
                        OP_CONJ: begin
                            re_d     = RW'(r1);
                            im_d     = conj_im;
                            neg_im_d = (i1 != '0);
                        end
                        default: begin
                            re_d = '0;
                            im_d = '0;
                            oe_d = 1'b1;
                        end
                    endcase
                end
            end
            DIV: begin
                if (re_done && im_done) begin
                    state_d  = DONE;
                    re_d     = div_re;
                    im_d     = nneg_q ? (RW'(0) - im_mag) : im_mag;
                    neg_re_d = 1'b0;
                    neg_im_d = nneg_q && (im_mag != '0);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            re_q     <= '0;
            im_q     <= '0;
            neg_re_q <= 1'b0;
            neg_im_q <= 1'b0;
            dz_q     <= 1'b0;
            oe_q     <= 1'b0;
            nneg_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            re_q     <= re_d;
            im_q     <= im_d;
            neg_re_q <= neg_re_d;
            neg_im_q <= neg_im_d;
            dz_q     <= dz_d;
            oe_q     <= oe_d;
            nneg_q   <= nneg_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign re_out    = re_q;
    assign im_out    = im_q;
    assign neg_re    = neg_re_q;
    assign neg_im    = neg_im_q;
    assign div_zero  = dz_q;
    assign op_err    = oe_q;
endmodule

// File: tb/tb_complex_alu_seq.sv
// Directed vector table plus handshake, backpressure and reset sequences.
// Expected values are hand-computed constants.
module tb_complex_alu_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic [7:0]  r1 = 8'd0, i1 = 8'd0, r2 = 8'd0, i2 = 8'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] re_out, im_out;
    logic        neg_re, neg_im, div_zero, op_err;

    int total = 0;
    int passed = 0;

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  r1, i1, r2, i2;
        logic [15:0] re, im;
        logic [3:0]  flags;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    complex_alu_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .r1        (r1),
        .i1        (i1),
        .r2        (r2),
        .i2        (i2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .re_out    (re_out),
        .im_out    (im_out),
        .neg_re    (neg_re),
        .neg_im    (neg_im),
        .div_zero  (div_zero),
        .op_err    (op_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            passed++;
    endtask

    task automatic drive(input logic [2:0] o, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] d);
        op = o; r1 = a; i1 = b; r2 = c; i2 = d;
        in_valid = 1'b1;
    endtask

    // flags packed as {neg_re, neg_im, div_zero, op_err}
    task automatic run_vec(input int idx, input vec_t v);
        int n;
        @(negedge clk);
        drive(v.op, v.r1, v.i1, v.r2, v.i2);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk($sformatf("v%0d latency", idx), n, v.lat);
        chk($sformatf("v%0d re", idx), {16'd0, re_out}, {16'd0, v.re});
        chk($sformatf("v%0d im", idx), {16'd0, im_out}, {16'd0, v.im});
        chk($sformatf("v%0d flags", idx),
            {28'd0, neg_re, neg_im, div_zero, op_err}, {28'd0, v.flags});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk($sformatf("v%0d release", idx), {30'd0, out_valid, in_ready},
            32'd1);
    endtask

    initial begin
        vecs[0]  = '{3'd0, 8'd255, 8'd255, 8'd255, 8'd255,
                     16'd510, 16'd510, 4'b0000, 0};
        vecs[1]  = '{3'd0, 8'd1, 8'd2, 8'd3, 8'd4,
                     16'd4, 16'd6, 4'b0000, 0};
        vecs[2]  = '{3'd1, 8'd3, 8'd9, 8'd10, 8'd2,
                     16'hFFF9, 16'd7, 4'b1000, 0};
        vecs[3]  = '{3'd1, 8'd200, 8'd0, 8'd100, 8'd5,
                     16'd100, 16'hFFFB, 4'b0100, 0};
        vecs[4]  = '{3'd2, 8'd3, 8'd4, 8'd5, 8'd6,
                     16'hFFF7, 16'd38, 4'b1000, 0};
        vecs[5]  = '{3'd2, 8'd255, 8'd255, 8'd255, 8'd255,
                     16'h0000, 16'hFC02, 4'b0100, 0};
        vecs[6]  = '{3'd4, 8'd5, 8'd9, 8'd1, 8'd1,
                     16'd5, 16'hFFF7, 4'b0100, 0};
        vecs[7]  = '{3'd4, 8'd0, 8'd0, 8'd7, 8'd7,
                     16'd0, 16'd0, 4'b0000, 0};
        vecs[8]  = '{3'd3, 8'd10, 8'd5, 8'd3, 8'd4,
                     16'd2, 16'hFFFF, 4'b0100, 17};
        vecs[9]  = '{3'd3, 8'd7, 8'd7, 8'd0, 8'd0,
                     16'hFFFF, 16'hFFFF, 4'b0010, 0};
        vecs[10] = '{3'd7, 8'd1, 8'd2, 8'd3, 8'd4,
                     16'd0, 16'd0, 4'b0001, 0};
        vecs[11] = '{3'd5, 8'd9, 8'd9, 8'd9, 8'd9,
                     16'd0, 16'd0, 4'b0001, 0};
        vecs[12] = '{3'd3, 8'd255, 8'd255, 8'd1, 8'd0,
                     16'd255, 16'd255, 4'b0000, 17};
        vecs[13] = '{3'd3, 8'd100, 8'd0, 8'd7, 8'd0,
                     16'd14, 16'd0, 4'b0000, 17};
        vecs[14] = '{3'd3, 8'd10, 8'd0, 8'd0, 8'd3,
                     16'd0, 16'hFFFD, 4'b0100, 17};
        vecs[15] = '{3'd3, 8'd1, 8'd0, 8'd255, 8'd255,
                     16'd0, 16'd0, 4'b0000, 17};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset handshake", {30'd0, in_ready, out_valid}, 32'd2);
        chk("reset data", {re_out, im_out}, 32'd0);
        chk("reset flags", {28'd0, neg_re, neg_im, div_zero, op_err}, 32'd0);

        for (int k = 0; k < 16; k++) run_vec(k, vecs[k]);

        // backpressure: a held second request waits for the out handshake
        @(negedge clk);
        drive(3'd0, 8'd1, 8'd1, 8'd1, 8'd1);
        @(posedge clk);
        #1;
        drive(3'd1, 8'd9, 8'd2, 8'd4, 8'd5);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp hold %0d", c),
                {re_out, im_out[13:0], out_valid, in_ready},
                {16'd2, 14'd2, 1'b1, 1'b0});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp release", {30'd0, out_valid, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp second op", {re_out, im_out}, {16'd5, 16'hFFFD});
        chk("bp second flags", {28'd0, neg_re, neg_im, out_valid, op_err},
            32'd6);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // reset in the middle of a divide
        @(negedge clk);
        drive(3'd3, 8'd10, 8'd5, 8'd3, 8'd4);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid-div rst handshake", {30'd0, in_ready, out_valid}, 32'd2);
        chk("mid-div rst data", {re_out, im_out}, 32'd0);
        chk("mid-div rst flags",
            {28'd0, neg_re, neg_im, div_zero, op_err}, 32'd0);
        repeat (12) @(posedge clk);
        #1;
        chk("mid-div no late result", {31'd0, out_valid}, 32'd0);
        run_vec(99, vecs[0]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
